// File: rtl/ifd_prefetch_decode.sv
// PDP-8 instruction prefetch/decode unit: credit-limited prefetch queue fed by a fixed-latency read port.
// Define IFD_PERF_CNT_EN to add saturating fetch/flush/discard performance counters.
module ifd_prefetch_decode #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_RD_LAT = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 12'o0200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  ifu_rd_req,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  dec_ready,
  output logic                  dec_valid,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic [DATA_WIDTH-1:0] dec_instr,
  output logic [2:0]            dec_opcode,
  output logic                  dec_indirect,
  output logic [ADDR_WIDTH-1:0] dec_base_addr,
  output logic                  dec_is_mem,
  output logic                  dec_is_iot,
  output logic                  dec_is_op7
`ifdef IFD_PERF_CNT_EN
  ,
  output logic [15:0]           perf_fetch_cnt,
  output logic [15:0]           perf_flush_cnt,
  output logic [15:0]           perf_discard_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 3;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  epoch;

  logic [MEM_RD_LAT-1:0] pipe_valid;
  logic [MEM_RD_LAT-1:0] pipe_epoch;
  logic [ADDR_WIDTH-1:0] pipe_addr [MEM_RD_LAT];

  logic [ADDR_WIDTH-1:0] q_pc    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic [2:0]            in_flight;
  logic [OCC_W-1:0]      occupancy;
  logic                  emerge_valid;
  logic                  emerge_match;
  logic                  push;
  logic                  pop;

  logic [ADDR_WIDTH-1:0] head_pc;
  logic [DATA_WIDTH-1:0] head_instr;
  logic [2:0]            head_op;
  logic                  head_is_mem;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < MEM_RD_LAT; i++) begin
      in_flight = in_flight + {2'b00, pipe_valid[i]};
    end
  end

  // Every outstanding request reserves a queue slot, so the queue can never overflow.
  assign occupancy    = OCC_W'(count) + OCC_W'(in_flight);
  assign ifu_rd_req   = reset_n && !redirect && (occupancy < DEPTH_OCC);
  assign ifu_rd_addr  = ifu_rd_req ? fetch_pc : '0;

  assign emerge_valid = pipe_valid[MEM_RD_LAT-1];
  assign emerge_match = (pipe_epoch[MEM_RD_LAT-1] == epoch);
  assign push         = emerge_valid && emerge_match && !redirect;
  assign dec_valid    = (count != '0) && !redirect;
  assign pop          = dec_valid && dec_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      epoch    <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      epoch    <= ~epoch;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (ifu_rd_req) fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
      if (push)       wr_ptr   <= wr_ptr + PTR_W'(1);
      if (pop)        rd_ptr   <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // On redirect, in-flight entries are re-stamped with the epoch being retired, so
  // back-to-back redirects (which toggle the epoch back) still leave them stale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid <= '0;
      pipe_epoch <= '0;
    end else begin
      pipe_valid[0] <= ifu_rd_req;
      pipe_epoch[0] <= epoch;
      for (int i = 1; i < MEM_RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_epoch[i] <= redirect ? epoch : pipe_epoch[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_addr[0] <= fetch_pc;
    for (int i = 1; i < MEM_RD_LAT; i++) begin
      pipe_addr[i] <= pipe_addr[i-1];
    end
    if (push) begin
      q_pc[wr_ptr]    <= pipe_addr[MEM_RD_LAT-1];
      q_instr[wr_ptr] <= ifu_rd_data;
    end
  end

  assign head_pc     = q_pc[rd_ptr];
  assign head_instr  = q_instr[rd_ptr];
  assign head_op     = head_instr[11:9];
  assign head_is_mem = (head_op < 3'd6);

  // Decode fields read as zero whenever nothing valid is presented.
  always_comb begin
    dec_pc        = '0;
    dec_instr     = '0;
    dec_opcode    = '0;
    dec_indirect  = 1'b0;
    dec_base_addr = '0;
    dec_is_mem    = 1'b0;
    dec_is_iot    = 1'b0;
    dec_is_op7    = 1'b0;
    if (dec_valid) begin
      dec_pc     = head_pc;
      dec_instr  = head_instr;
      dec_opcode = head_op;
      dec_is_mem = head_is_mem;
      dec_is_iot = (head_op == 3'd6);
      dec_is_op7 = (head_op == 3'd7);
      if (head_is_mem) begin
        dec_indirect  = head_instr[8];
        dec_base_addr = head_instr[7] ? {head_pc[ADDR_WIDTH-1:7], head_instr[6:0]}
                                      : {{(ADDR_WIDTH-7){1'b0}}, head_instr[6:0]};
      end
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (count == DEPTH_CNT)));

`ifdef IFD_PERF_CNT_EN
  logic drop;

  // A response that arrives during a redirect is dropped along with the flush.
  assign drop = emerge_valid && !push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt   <= '0;
      perf_flush_cnt   <= '0;
      perf_discard_cnt <= '0;
    end else begin
      if (ifu_rd_req && (perf_fetch_cnt != 16'hFFFF))  perf_fetch_cnt   <= perf_fetch_cnt + 16'd1;
      if (redirect && (perf_flush_cnt != 16'hFFFF))    perf_flush_cnt   <= perf_flush_cnt + 16'd1;
      if (drop && (perf_discard_cnt != 16'hFFFF))      perf_discard_cnt <= perf_discard_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifd_prefetch_decode.sv
// Scoreboard bench for ifd_prefetch_decode: directed stall, redirect, wrap, decode and mid-run reset scenarios.
module tb_ifd_prefetch_decode;

  localparam int LAT   = 3;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [11:0] pc;
    logic [11:0] instr;
    logic [2:0]  op;
    logic        ind;
    logic [11:0] base;
    logic        mem;
    logic        iot;
    logic        op7;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifu_rd_req;
  logic [11:0] ifu_rd_addr;
  logic [11:0] ifu_rd_data;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [11:0] dec_pc;
  logic [11:0] dec_instr;
  logic [2:0]  dec_opcode;
  logic        dec_indirect;
  logic [11:0] dec_base_addr;
  logic        dec_is_mem;
  logic        dec_is_iot;
  logic        dec_is_op7;
`ifdef IFD_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_flush_cnt;
  logic [15:0] perf_discard_cnt;
`endif

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mon_got;
  exp_t mon_want;
  logic [11:0] mem_pipe [LAT];
  int   req_cnt;
  int   first_valid;
  int   wait_n;

  ifd_prefetch_decode #(
    .ADDR_WIDTH(12), .DATA_WIDTH(12), .FIFO_DEPTH(DEPTH), .MEM_RD_LAT(LAT), .RESET_PC(12'o0200)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_ready(dec_ready), .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .dec_opcode(dec_opcode), .dec_indirect(dec_indirect), .dec_base_addr(dec_base_addr),
    .dec_is_mem(dec_is_mem), .dec_is_iot(dec_is_iot), .dec_is_op7(dec_is_op7)
`ifdef IFD_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_discard_cnt(perf_discard_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory image: data equals address except for a few hand-picked decode vectors.
  function automatic logic [11:0] mem_word(input logic [11:0] a);
    case (a)
      12'o0400: return 12'o1377;
      12'o0401: return 12'o7200;
      12'o0402: return 12'o6031;
      12'o0403: return 12'o5723;
      12'o0404: return 12'o7777;
      12'o0405: return 12'o2045;
      default:  return a;
    endcase
  endfunction

  always @(posedge clk) begin
    mem_pipe[0] <= ifu_rd_addr;
    for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end

  assign ifu_rd_data = mem_word(mem_pipe[LAT-1]);

  function automatic exp_t model_entry(input logic [11:0] pc);
    exp_t e;
    logic [11:0] w;
    w       = mem_word(pc);
    e.pc    = pc;
    e.instr = w;
    e.op    = w[11:9];
    e.mem   = (e.op < 3'd6);
    e.iot   = (e.op == 3'd6);
    e.op7   = (e.op == 3'd7);
    e.ind   = e.mem ? w[8] : 1'b0;
    if (!e.mem)     e.base = 12'o0000;
    else if (w[7])  e.base = (pc & 12'o7600) | (w & 12'o0177);
    else            e.base = w & 12'o0177;
    return e;
  endfunction

  function automatic exp_t hand(input logic [11:0] pc, input logic [11:0] instr, input logic [2:0] op,
                                input logic ind, input logic [11:0] base, input logic m,
                                input logic i, input logic s);
    exp_t e;
    e = {pc, instr, op, ind, base, m, i, s};
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0o, expected %0o (octal)", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic redir_v, input logic [11:0] rpc,
                               input logic rdy);
    @(posedge clk);
    #1;
    reset_n     = rst_v;
    redirect    = redir_v;
    redirect_pc = rpc;
    dec_ready   = rdy;
  endtask

  task automatic pushRange(input logic [11:0] first, input int n);
    for (int i = 0; i < n; i++) sb.push_back(model_entry(first + 12'(i)));
  endtask

  task automatic drainScoreboard(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sb.size() != 0 && n < 60);
    dec_ready = 1'b0;
    checkOutput(name, 32'(sb.size()), 0);
    sb.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req"},   32'(ifu_rd_req), 0);
    checkOutput({tag, "_addr"},  32'(ifu_rd_addr), 0);
    checkOutput({tag, "_valid"}, 32'(dec_valid), 0);
    checkOutput({tag, "_pc"},    32'(dec_pc), 0);
    checkOutput({tag, "_instr"}, 32'(dec_instr), 0);
    checkOutput({tag, "_mem"},   32'(dec_is_mem), 0);
`ifdef IFD_PERF_CNT_EN
    checkOutput({tag, "_perf_fetch"},   32'(perf_fetch_cnt), 0);
    checkOutput({tag, "_perf_flush"},   32'(perf_flush_cnt), 0);
    checkOutput({tag, "_perf_discard"}, 32'(perf_discard_cnt), 0);
`endif
  endtask

  // Monitor: every accepted instruction is compared against the next scoreboard entry.
  always @(negedge clk) begin
    if (reset_n && dec_valid && dec_ready) begin
      tests++;
      mon_got = {dec_pc, dec_instr, dec_opcode, dec_indirect, dec_base_addr,
                 dec_is_mem, dec_is_iot, dec_is_op7};
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_pop: got pc=%0o instr=%0o, no entry expected", dec_pc, dec_instr);
      end else begin
        mon_want = sb.pop_front();
        if (mon_got !== mon_want) begin
          fails++;
          $display("[TB] FAIL sb_entry: got pc=%0o instr=%0o op=%0d ind=%0b base=%0o mio=%b%b%b, expected pc=%0o instr=%0o op=%0d ind=%0b base=%0o mio=%b%b%b",
                   mon_got.pc, mon_got.instr, mon_got.op, mon_got.ind, mon_got.base,
                   mon_got.mem, mon_got.iot, mon_got.op7,
                   mon_want.pc, mon_want.instr, mon_want.op, mon_want.ind, mon_want.base,
                   mon_want.mem, mon_want.iot, mon_want.op7);
        end
      end
    end
  end

  initial begin
    reset_n     = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 12'o0000;
    dec_ready   = 1'b0;
    #2 reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");

    // Stall from reset: the queue fills, fetch stops, the head holds.
    applyStimulus(1'b1, 1'b0, 12'o0000, 1'b0);
    req_cnt     = 0;
    first_valid = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checkOutput("first_req", 32'(ifu_rd_req), 1);
        checkOutput("first_addr", 32'(ifu_rd_addr), 32'o0200);
      end
      if (ifu_rd_req) req_cnt++;
      if (dec_valid && first_valid < 0) first_valid = c;
    end
    checkOutput("first_valid_cycle", 32'(first_valid), LAT + 1);
    checkOutput("stall_req_count", 32'(req_cnt), DEPTH);
    checkOutput("stall_req_idle", 32'(ifu_rd_req), 0);
    checkOutput("stall_head_valid", 32'(dec_valid), 1);
    checkOutput("stall_head_pc", 32'(dec_pc), 32'o0200);
    checkOutput("stall_head_instr", 32'(dec_instr), 32'o0200);

    // Release: drain in order at one per cycle, fetch resumes after the first pop.
    pushRange(12'o0200, 16);
    applyStimulus(1'b1, 1'b0, 12'o0000, 1'b1);
    @(negedge clk);
    checkOutput("no_fetch_before_pop", 32'(ifu_rd_req), 0);
    @(negedge clk);
    checkOutput("resume_req", 32'(ifu_rd_req), 1);
    checkOutput("resume_addr", 32'(ifu_rd_addr), 32'o0210);
    repeat (15) @(posedge clk);
    #1;
    checkOutput("drain_throughput", 32'(sb.size()), 0);
    sb.delete();
    dec_ready = 1'b0;

    // Redirect to 3000 with three requests in flight.
    applyStimulus(1'b0, 1'b0, 12'o0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 12'o0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 12'o0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 12'o0000, 1'b0);
    pushRange(12'o3000, 6);
    applyStimulus(1'b1, 1'b1, 12'o3000, 1'b1);
    @(negedge clk);
    checkOutput("redir_no_req", 32'(ifu_rd_req), 0);
    checkOutput("redir_valid", 32'(dec_valid), 0);
    applyStimulus(1'b1, 1'b0, 12'o0000, 1'b1);
    @(negedge clk);
    checkOutput("post_redir_req", 32'(ifu_rd_req), 1);
    checkOutput("post_redir_addr", 32'(ifu_rd_addr), 32'o3000);
    checkOutput("post_redir_valid", 32'(dec_valid), 0);
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!dec_valid && wait_n < 20);
    checkOutput("redir_first_valid", 32'(wait_n), LAT + 1);
    drainScoreboard("drain_redirect");

    // Back-to-back redirects with a non-empty queue; the last one (7776) wins and wraps.
    pushRange(12'o7776, 4);
    applyStimulus(1'b1, 1'b1, 12'o5555, 1'b1);
    @(negedge clk);
    checkOutput("redir1_valid", 32'(dec_valid), 0);
    applyStimulus(1'b1, 1'b1, 12'o7776, 1'b1);
    @(negedge clk);
    checkOutput("redir2_valid", 32'(dec_valid), 0);
    checkOutput("redir2_no_req", 32'(ifu_rd_req), 0);
    applyStimulus(1'b1, 1'b0, 12'o0000, 1'b1);
    @(negedge clk);
    checkOutput("wrap_addr", 32'(ifu_rd_addr), 32'o7776);
    drainScoreboard("drain_wrap");

    // Decode vectors with hand-computed fields.
    sb.push_back(hand(12'o0400, 12'o1377, 3'd1, 1'b0, 12'o0577, 1'b1, 1'b0, 1'b0));
    sb.push_back(hand(12'o0401, 12'o7200, 3'd7, 1'b0, 12'o0000, 1'b0, 1'b0, 1'b1));
    sb.push_back(hand(12'o0402, 12'o6031, 3'd6, 1'b0, 12'o0000, 1'b0, 1'b1, 1'b0));
    sb.push_back(hand(12'o0403, 12'o5723, 3'd5, 1'b1, 12'o0523, 1'b1, 1'b0, 1'b0));
    sb.push_back(hand(12'o0404, 12'o7777, 3'd7, 1'b0, 12'o0000, 1'b0, 1'b0, 1'b1));
    sb.push_back(hand(12'o0405, 12'o2045, 3'd2, 1'b0, 12'o0045, 1'b1, 1'b0, 1'b0));
    applyStimulus(1'b1, 1'b1, 12'o0400, 1'b1);
    applyStimulus(1'b1, 1'b0, 12'o0000, 1'b1);
    drainScoreboard("drain_decode");

    // Asynchronous reset mid-stream, then a clean restart at 0200.
    applyStimulus(1'b1, 1'b0, 12'o0000, 1'b0);
    @(negedge clk);
    checkOutput("busy_before_reset", 32'(dec_valid), 1);
    #3 reset_n = 1'b0;
    #1;
    checkAllZero("midreset");
    pushRange(12'o0200, 4);
    applyStimulus(1'b1, 1'b0, 12'o0000, 1'b1);
    @(negedge clk);
    checkOutput("restart_addr", 32'(ifu_rd_addr), 32'o0200);
    drainScoreboard("drain_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifd_prefetch_decode.md
Name: ifd_prefetch_decode

Overview:
- Next-generation PDP-8 instruction fetch/decode unit.
- Replaces the single-entry fetch-on-demand decoder with a parametrised prefetch queue, a fixed-latency pipelined memory read port, and PC redirect (flush) support.
- Sits between the memory read port and the execution unit.
- Delivers decoded instructions over a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 12: memory address width.
- DATA_WIDTH, 12: instruction word width. Decode fields assume the PDP-8 layout, so this must equal 12.
- FIFO_DEPTH, 4: prefetch queue entries. Power of two, 2..16.
- MEM_RD_LAT, 1: cycles from ifu_rd_req to valid ifu_rd_data. Range 1..4.
- RESET_PC, 12'o0200: first fetch address after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ifu_rd_req  out  1  read request, one word per cycle.
- ifu_rd_addr  out  ADDR_WIDTH  read address; valid when ifu_rd_req=1.
- ifu_rd_data  in  DATA_WIDTH  read data, valid exactly MEM_RD_LAT cycles after the request.
- redirect  in  1  execute unit taken jump/skip; flush the queue and refetch.
- redirect_pc  in  ADDR_WIDTH  new fetch address; sampled when redirect=1.
- dec_ready  in  1  execute unit accepts the head entry (the inverse of the old stall).
- dec_valid  out  1  head entry valid.
- dec_pc  out  ADDR_WIDTH  address of the head instruction.
- dec_instr  out  DATA_WIDTH  raw instruction word.
- dec_opcode  out  3  instr[11:9].
- dec_indirect  out  1  instr[8]; forced 0 when opcode>=6.
- dec_base_addr  out  ADDR_WIDTH  effective base: instr[7] ? {dec_pc[11:7],instr[6:0]} : {5'b0,instr[6:0]}. Forced 0 when opcode>=6.
- dec_is_mem  out  1  opcode<6.
- dec_is_iot  out  1  opcode==6.
- dec_is_op7  out  1  opcode==7.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - fetch PC = RESET_PC; queue empty; in-flight pipeline cleared; epoch=0.
  - ifu_rd_req=0, ifu_rd_addr=0, dec_valid=0, all dec_* outputs 0.
- Credit rule: issue ifu_rd_req in a cycle only when (queue occupancy + in-flight requests) < FIFO_DEPTH and redirect=0. On issue, ifu_rd_addr = fetch PC and fetch PC increments mod 2^ADDR_WIDTH (7777 wraps to 0000).
- In-flight tracking: a MEM_RD_LAT-deep shift pipeline carrying {valid, addr, epoch}. When an entry emerges with a matching epoch, write {addr, ifu_rd_data} to the queue tail. An epoch mismatch discards the entry. The credit rule guarantees the queue never overflows; an overflow is an RTL error (assertion).
- Output: dec_valid = !empty && !redirect. Decode fields are combinational from the head entry. Pop on dec_valid && dec_ready. Head data is held stable while dec_valid=1 and dec_ready=0.
- Redirect (single cycle):
  - queue flushed, epoch toggles, fetch PC = redirect_pc.
  - no request issued in the redirect cycle; the first request at redirect_pc issues the next cycle.
  - any dec_ready in that cycle is ignored; no pop occurs.
- Redirect on consecutive cycles: the last one wins; all earlier in-flight data is discarded.
- Simultaneous push and pop: occupancy unchanged; both take effect.
- Full queue: no requests are issued. The fetch PC holds until a pop frees a credit; a request issues the cycle after the pop.
- Empty queue with dec_ready=1: dec_valid=0, nothing happens.
- Reset mid-operation: everything returns to reset values immediately. Late memory data arriving after reset deasserts is ignored because the pipeline valids are cleared.
- Throughput: with dec_ready held at 1, one instruction per cycle in steady state.
- First dec_valid after reset or redirect: MEM_RD_LAT+1 cycles after the first request edge.

Optional Feature:
- Macro: IFD_PERF_CNT_EN.
- Defined: adds output ports perf_fetch_cnt [15:0], perf_flush_cnt [15:0] and perf_discard_cnt [15:0].
  - perf_fetch_cnt counts issued requests.
  - perf_flush_cnt counts redirect cycles.
  - perf_discard_cnt counts in-flight responses dropped on epoch mismatch.
  - All counters saturate at 16'hFFFF and reset to 0.
- Not defined: the ports and logic are absent. Functional behaviour is identical in both cases.

Test Plan:
- Reset, dec_ready=1, memory returns mem[a]=a: requests at 0200, 0201, 0202…; first dec_valid with dec_pc=0200 at cycle MEM_RD_LAT+1; then one instruction per cycle, in order.
- Decode check: instr 12'o1377 at pc 0400 → opcode=1, indirect=0, base_addr=12'o0577, is_mem=1. Instr 12'o7200 → is_op7=1, base_addr=0.
- dec_ready=0 for 10 cycles: exactly FIFO_DEPTH requests issue, then ifu_rd_req stays 0 and head fields hold. Releasing dec_ready drains the entries in order, and fetch resumes the cycle after the first pop.
- redirect=1, redirect_pc=12'o3000 while 3 requests are in flight with MEM_RD_LAT=3: the cycle after redirect, dec_valid=0; the first request is at 3000; no stale word is ever presented; the next dec_pc is 3000.
- Fetch PC wrap: redirect to 7776 → dec_pc sequence 7776, 7777, 0000, 0001.
- Assert reset_n while the queue is full and requests are in flight: all outputs go to 0 immediately; after release, fetching restarts at 0200 with no stale data. With IFD_PERF_CNT_EN defined, the counters read 0.
